vend_sequencer: RTL
===================

Name: vend_sequencer

Overview:
Transaction controller for the vending machine datapath. It accumulates inserted credit and accepts product selections. It queries the stock/price datapath, then decrements stock, handshakes the dispense and change outputs, and reports errors. It sits between the front-panel inputs (coins, keys) and the stock/charge datapath, which owns item counts and prices.

Parameters:
ITEM_W, 2, width of item index (2**ITEM_W items)
CREDIT_W, 8, credit/price/change width
MAX_CREDIT, 200, credit ceiling; a coin that would exceed it is rejected

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
coin_valid  in  1  one-cycle strobe, coin inserted
coin_value  in  4  coin value in credit units
sel_valid  in  1  one-cycle strobe, item selected
sel_item  in  ITEM_W  selected item index
cancel  in  1  one-cycle strobe, abort and refund
stock_idx  out  ITEM_W  item index presented to datapath lookup
stock_cnt  in  8  stock count for stock_idx, combinational from datapath
price  in  CREDIT_W  price for stock_idx, combinational from datapath
stock_dec  out  1  one-cycle strobe: datapath decrements stock_idx count
dispense_valid  out  1  dispense request, held until accepted
dispense_item  out  ITEM_W  item being dispensed
dispense_ready  in  1  dispenser accepts
change_valid  out  1  change request, held until accepted
change_amount  out  CREDIT_W  change value
change_ready  in  1  change unit accepts
coin_reject  out  1  one-cycle strobe: last coin returned, not credited
credit  out  CREDIT_W  current credit
error  out  1  one-cycle error strobe
err_code  out  2  0 none, 1 no credit, 2 insufficient credit, 3 out of stock
busy  out  1  high in CHECK, DISPENSE, CHANGE

Behaviour:
- Reset (async, any state): state IDLE; credit 0; stock_idx 0; every strobe, valid and err_code output 0.
- All outputs are registered, except busy and the valid/amount outputs, which decode directly from state/registers.
- States: IDLE, CREDIT, CHECK, DISPENSE, CHANGE.
- Input priority per cycle in IDLE/CREDIT: cancel > coin > select. A lower-priority strobe in the same cycle is dropped. A dropped coin pulses coin_reject next cycle.
- Coin in IDLE/CREDIT: if credit+coin_value <= MAX_CREDIT, credit updates next cycle and state goes to CREDIT. Otherwise coin_reject pulses and credit is unchanged. Sum computed at CREDIT_W+1 bits; no wrap.
- Coin in CHECK/DISPENSE/CHANGE: coin_reject pulses; credit unchanged.
- Select in IDLE (credit 0): error, err_code=1; stay IDLE.
- Select in CREDIT: latch sel_item into stock_idx; go to CHECK.
- CHECK lasts exactly 1 cycle and samples stock_cnt/price:
  - stock_cnt==0: error, err_code=3; return to CREDIT with credit kept.
  - else credit<price: error, err_code=2; return to CREDIT.
  - else credit -= price; stock_dec pulses in the cycle after CHECK; err_code=0; go to DISPENSE.
- DISPENSE: dispense_valid=1 and dispense_item=stock_idx until dispense_ready is sampled high. Then go to CHANGE if credit>0, else IDLE.
- Latency from select strobe to dispense_valid is 2 cycles.
- CHANGE: change_valid=1 and change_amount=credit until change_ready. Then credit=0; go to IDLE.
- Cancel in CREDIT: go to CHANGE. Cancel in IDLE or busy states is ignored.
- Selects arriving while busy are ignored; they produce no error.
- err_code holds until the next error or the next successful CHECK.
- A ready input sampled while the corresponding valid is low has no effect.

Decomposition:
- Package vend_pkg holds:
  - state enum;
  - err_code constants ERR_NONE/ERR_NOCREDIT/ERR_INSUFF/ERR_NOSTOCK;
  - default widths.
- Sub-module vend_credit_acc is natural: saturating-check adder/subtractor with the credit register and coin_reject generation.
- The FSM stays in vend_sequencer.

Test Plan:
- Coins 5,5,10; select item 1 (price 15, stock 3) -> credit 20; stock_dec once for item 1; dispense_valid with item 1 2 cycles after select; change_amount 5; credit 0; IDLE.
- Credit 10; select item 2 (price 15) -> error, err_code=2; credit stays 10; state CREDIT; no stock_dec.
- Credit 20; select item 0 with stock_cnt 0 -> err_code=3; then cancel -> change_valid with change_amount 20, credit 0 after change_ready.
- Credit 195, coin 10 (MAX 200) -> coin_reject pulse; credit 195. Coin during DISPENSE -> coin_reject.
- Same-cycle cancel+coin 5 with credit 10 -> CHANGE with amount 10; coin_reject pulse. Same-cycle coin+select -> coin credited, select dropped.
- rst asserted mid-DISPENSE with dispense_ready low -> all outputs 0 immediately (async); credit 0; IDLE; no stock_dec after release.

Source files
------------

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared states, error codes and default widths for the vending sequencer
package vend_pkg;

  localparam int ITEM_W_DEF     = 2;
  localparam int CREDIT_W_DEF   = 8;
  localparam int MAX_CREDIT_DEF = 200;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CREDIT,
    S_CHECK,
    S_DISPENSE,
    S_CHANGE
  } vend_state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_NOCREDIT = 2'd1;
  localparam logic [1:0] ERR_INSUFF   = 2'd2;
  localparam logic [1:0] ERR_NOSTOCK  = 2'd3;

endpackage

// File: rtl/vend_credit_acc.sv
// rtl/vend_credit_acc.sv - credit register with ceiling-checked coin add, price subtract and coin reject
module vend_credit_acc #(
  parameter int CREDIT_W   = 8,
  parameter int MAX_CREDIT = 200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [3:0]          coin_value,
  input  logic                coin_allow,
  input  logic                sub_en,
  input  logic [CREDIT_W-1:0] sub_amount,
  input  logic                clr,
  output logic                coin_ok,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit
);

  // One extra bit so a sum past the ceiling is seen rather than wrapped
  logic [CREDIT_W:0] sum;

  always_comb begin
    sum     = {1'b0, credit} + (CREDIT_W+1)'(coin_value);
    coin_ok = coin_valid && coin_allow && (sum <= (CREDIT_W+1)'(MAX_CREDIT));
  end

  // clr, sub_en and coin_ok are mutually exclusive by FSM state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit      <= '0;
      coin_reject <= 1'b0;
    end else begin
      coin_reject <= coin_valid && !coin_ok;
      if (clr)
        credit <= '0;
      else if (sub_en)
        credit <= credit - sub_amount;
      else if (coin_ok)
        credit <= sum[CREDIT_W-1:0];
    end
  end

endmodule

// File: rtl/vend_sequencer.sv
// rtl/vend_sequencer.sv - vending transaction FSM: credit, select, stock check, dispense and change
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int ITEM_W     = ITEM_W_DEF,
  parameter int CREDIT_W   = CREDIT_W_DEF,
  parameter int MAX_CREDIT = MAX_CREDIT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [3:0]          coin_value,
  input  logic                sel_valid,
  input  logic [ITEM_W-1:0]   sel_item,
  input  logic                cancel,
  output logic [ITEM_W-1:0]   stock_idx,
  input  logic [7:0]          stock_cnt,
  input  logic [CREDIT_W-1:0] price,
  output logic                stock_dec,
  output logic                dispense_valid,
  output logic [ITEM_W-1:0]   dispense_item,
  input  logic                dispense_ready,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amount,
  input  logic                change_ready,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                error,
  output logic [1:0]          err_code,
  output logic                busy
);

  vend_state_t         state, state_d;
  logic [ITEM_W-1:0]   stock_idx_d;
  logic                stock_dec_d;
  logic                error_d;
  logic [1:0]          err_code_d;
  logic                sub_en;
  logic                clr;
  logic                coin_allow;
  logic                coin_ok;

  // Cancel outranks a coin in the same cycle, so such a coin is bounced
  assign coin_allow = ((state == S_IDLE) || (state == S_CREDIT)) && !cancel;

  vend_credit_acc #(
    .CREDIT_W   (CREDIT_W),
    .MAX_CREDIT (MAX_CREDIT)
  ) u_credit (
    .clk         (clk),
    .rst         (rst),
    .coin_valid  (coin_valid),
    .coin_value  (coin_value),
    .coin_allow  (coin_allow),
    .sub_en      (sub_en),
    .sub_amount  (price),
    .clr         (clr),
    .coin_ok     (coin_ok),
    .coin_reject (coin_reject),
    .credit      (credit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      stock_idx <= '0;
      stock_dec <= 1'b0;
      error     <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state     <= state_d;
      stock_idx <= stock_idx_d;
      stock_dec <= stock_dec_d;
      error     <= error_d;
      err_code  <= err_code_d;
    end
  end

  always_comb begin
    state_d     = state;
    stock_idx_d = stock_idx;
    stock_dec_d = 1'b0;
    error_d     = 1'b0;
    err_code_d  = err_code;
    sub_en      = 1'b0;
    clr         = 1'b0;
    case (state)
      S_IDLE: begin
        if (!cancel) begin
          if (coin_valid) begin
            if (coin_ok) state_d = S_CREDIT;
          end else if (sel_valid) begin
            error_d    = 1'b1;
            err_code_d = ERR_NOCREDIT;
          end
        end
      end
      S_CREDIT: begin
        if (cancel) begin
          state_d = S_CHANGE;
        end else if (!coin_valid && sel_valid) begin
          stock_idx_d = sel_item;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        // stock_cnt/price are the datapath's view of the item latched last cycle
        if (stock_cnt == 8'd0) begin
          error_d    = 1'b1;
          err_code_d = ERR_NOSTOCK;
          state_d    = S_CREDIT;
        end else if (credit < price) begin
          error_d    = 1'b1;
          err_code_d = ERR_INSUFF;
          state_d    = S_CREDIT;
        end else begin
          sub_en      = 1'b1;
          stock_dec_d = 1'b1;
          err_code_d  = ERR_NONE;
          state_d     = S_DISPENSE;
        end
      end
      S_DISPENSE: begin
        if (dispense_ready) state_d = (credit != '0) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE: begin
        if (change_ready) begin
          clr     = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy           = (state == S_CHECK) || (state == S_DISPENSE) || (state == S_CHANGE);
  assign dispense_valid = (state == S_DISPENSE);
  assign dispense_item  = stock_idx;
  assign change_valid   = (state == S_CHANGE);
  assign change_amount  = credit;

endmodule
